// File: rtl/dog_stream_source_if.sv
// Pixel-in / DoG-triple-out bundle for dog_stream_source.
// Handshakes: g0..g3 move when in_valid && in_ready are both high on a rising edge.
// Diff1..3 are a beat only in a cycle with data_valid high; sink_busy high stops the next beat.
interface dog_stream_source_if;
  logic [7:0]  g0;
  logic [7:0]  g1;
  logic [7:0]  g2;
  logic [7:0]  g3;
  logic        in_valid;
  logic        in_ready;
  logic        sink_busy;
  logic [15:0] Diff1;
  logic [15:0] Diff2;
  logic [15:0] Diff3;
  logic        data_valid;

  modport slave (
    input  g0, g1, g2, g3, in_valid, sink_busy,
    output in_ready, Diff1, Diff2, Diff3, data_valid
  );

  modport master (
    output g0, g1, g2, g3, in_valid, sink_busy,
    input  in_ready, Diff1, Diff2, Diff3, data_valid
  );
endinterface

// File: rtl/dog_stream_source.sv
// Difference-of-Gaussian triple stream: diff stage -> FIFO -> output regs, one beat per pixel.
// Optional macro DOG_OFFSET_EN biases every difference by +256 so it is strictly positive.
module dog_stream_source #(
  parameter int N            = 450,
  parameter int M            = 600,
  parameter int FIFO_DEPTH   = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  dog_stream_source_if.slave s,
  output logic               frame_done,
  output logic [1:0]         dbg_state_o
);

  localparam int PIX = N * M;
  localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam logic [CW:0] THRESH = (CW+1)'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [PW-1:0] LAST_PIX = PW'(PIX - 1);

`ifdef DOG_OFFSET_EN
  localparam logic [15:0] DIFF_OFFSET = 16'd256;
`else
  localparam logic [15:0] DIFF_OFFSET = 16'd0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            stage_full_q;
  logic [47:0]     stage_q;
  logic [47:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            dv_q;
  logic [15:0]     d1_q, d2_q, d3_q;
  logic [CW:0]     occ;
  logic            in_ready;
  logic            accept;
  logic            push;
  logic            pop;

  function automatic logic [15:0] dog_diff(input logic [7:0] hi, input logic [7:0] lo);
    return ({8'h00, hi} - {8'h00, lo}) + DIFF_OFFSET;
  endfunction

  // The stage register always empties into the FIFO next cycle, so it counts as occupied space.
  assign occ      = {1'b0, count_q} + {{CW{1'b0}}, stage_full_q};
  assign in_ready = (state_q == S_STREAM) && (occ <= THRESH);
  assign accept   = s.in_valid && in_ready;
  assign push     = stage_full_q;
  assign pop      = (count_q != '0) && !s.sink_busy;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          pix_d   = '0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (pix_q == LAST_PIX) state_d = S_DRAIN;
          else                   pix_d   = pix_q + PW'(1);
        end
      end
      S_DRAIN: begin
        // The last pop is on the output this cycle once nothing is left behind it.
        if (!stage_full_q && (count_q == '0) && dv_q) begin
          state_d    = S_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_full_q <= 1'b0;
      stage_q      <= '0;
    end else begin
      stage_full_q <= accept;
      if (accept) begin
        stage_q <= {dog_diff(s.g1, s.g0), dog_diff(s.g2, s.g1), dog_diff(s.g3, s.g2)};
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= stage_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      dv_q <= pop;
      if (pop) {d1_q, d2_q, d3_q} <= mem_q[rd_ptr_q];
    end
  end

  assign s.in_ready   = in_ready;
  assign s.data_valid = dv_q;
  assign s.Diff1      = d1_q;
  assign s.Diff2      = d2_q;
  assign s.Diff3      = d3_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dog_stream_source.sv
// Bench for dog_stream_source on a 4x5 frame: directed diffs, backpressure, ignored start, mid-frame reset.
// Expected beats come from a plain-arithmetic difference model queued at each accepted pixel.
module tb_dog_stream_source;
  localparam int N      = 4;
  localparam int M      = 5;
  localparam int PIX    = N * M;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       frame_done;
  logic [1:0] dbg_state;

  dog_stream_source_if bus();

  dog_stream_source #(
    .N(N), .M(M), .FIFO_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .s(bus),
    .frame_done(frame_done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [47:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [47:0] obs_q[$];
  int          obs_cyc_q[$];
  int          fd_cnt = 0;
  int          fd_cyc = 0;
  int          fd0 = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          sent = 0;
  bit          have = 1'b0;
  bit          rand_busy = 1'b0;
  logic [7:0]  cur0, cur1, cur2, cur3;

  always @(negedge clk) begin
    if (bus.data_valid === 1'b1) begin
      obs_q.push_back({bus.Diff1, bus.Diff2, bus.Diff3});
      obs_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  // Reference: difference of the two scales as signed integers, optionally lifted by 256.
  function automatic logic [15:0] ref_diff(input int hi, input int lo);
    int d;
    d = hi - lo;
`ifdef DOG_OFFSET_EN
    d = d + 256;
`endif
    return d[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_frame();
    exp_q.delete();
    exp_cyc_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    sent  = 0;
    have  = 1'b0;
    fd0   = fd_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic stream(input int target, input int max_cyc, input bit gaps);
    for (int k = 0; k < max_cyc && sent < target; k++) begin
      if (!have) begin
        cur0 = 8'($urandom_range(0, 255));
        cur1 = 8'($urandom_range(0, 255));
        cur2 = 8'($urandom_range(0, 255));
        cur3 = 8'($urandom_range(0, 255));
        have = 1'b1;
      end
      bus.g0 = cur0;
      bus.g1 = cur1;
      bus.g2 = cur2;
      bus.g3 = cur3;
      bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rand_busy) bus.sink_busy = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back({ref_diff(int'(cur1), int'(cur0)),
                         ref_diff(int'(cur2), int'(cur1)),
                         ref_diff(int'(cur3), int'(cur2))});
        exp_cyc_q.push_back(cyc);
        sent++;
        have = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    bus.sink_busy = 1'b0;
    for (int k = 0; k < max_cyc && !ok; k++) begin
      tick(1);
      if (fd_cnt > fd0) ok = 1'b1;
    end
    tick(4);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.sink_busy = 1'b0;
    tick(3);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b want 0", bus.data_valid); end
    n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (bus.Diff1 !== 16'h0) begin n_fail++; $display("FAIL reset_diff1: got %h want 0000", bus.Diff1); end
    n_cmp++; if (bus.Diff2 !== 16'h0) begin n_fail++; $display("FAIL reset_diff2: got %h want 0000", bus.Diff2); end
    n_cmp++; if (bus.Diff3 !== 16'h0) begin n_fail++; $display("FAIL reset_diff3: got %h want 0000", bus.Diff3); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
  endtask

  task automatic test_directed();
    logic [47:0] e2, e3;
    bit          ok;
    int          last;
`ifdef DOG_OFFSET_EN
    e2 = {16'h010A, 16'h0114, 16'h00FB};
    e3 = {16'h0001, 16'h01FF, 16'h0001};
`else
    e2 = {16'h000A, 16'h0014, 16'hFFFB};
    e3 = {16'hFF01, 16'h00FF, 16'hFF01};
`endif
    bus.sink_busy = 1'b0;
    begin_frame();
    cur0 = 8'd10;  cur1 = 8'd20; cur2 = 8'd40;  cur3 = 8'd35; have = 1'b1;
    stream(1, 20, 1'b0);
    cur0 = 8'd255; cur1 = 8'd0;  cur2 = 8'd255; cur3 = 8'd0; have = 1'b1;
    stream(2, 20, 1'b0);
    tick(6);
    n_cmp++;
    if (obs_q.size() != 2 || exp_cyc_q.size() != 2) begin
      n_fail++; $display("FAIL directed_beats: got %0d beats want 2", obs_q.size());
    end else begin
      n_cmp++; if (obs_q[0] !== e2) begin n_fail++; $display("FAIL directed_pix_a: got %h want %h", obs_q[0], e2); end
      n_cmp++; if (obs_cyc_q[0] != exp_cyc_q[0] + 3) begin n_fail++; $display("FAIL latency_pix_a: got %0d want %0d", obs_cyc_q[0] - exp_cyc_q[0], 3); end
      n_cmp++; if (obs_q[1] !== e3) begin n_fail++; $display("FAIL directed_pix_b: got %h want %h", obs_q[1], e3); end
      n_cmp++; if (obs_cyc_q[1] != exp_cyc_q[1] + 3) begin n_fail++; $display("FAIL latency_pix_b: got %0d want %0d", obs_cyc_q[1] - exp_cyc_q[1], 3); end
    end
    rand_busy = 1'b1;
    stream(PIX, 600, 1'b1);
    rand_busy = 1'b0;
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL directed_frame_done: got none within 300 cycles want pulse"); end
    n_cmp++; if (obs_q.size() != PIX || exp_q.size() != PIX) begin n_fail++; $display("FAIL directed_count: got %0d beats / %0d sent want %0d", obs_q.size(), exp_q.size(), PIX); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL directed_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL directed_fd_pulses: got %0d want 1", fd_cnt - fd0); end
    if (obs_q.size() > 0) begin
      last = obs_cyc_q[obs_cyc_q.size()-1];
      n_cmp++; if (fd_cyc < last) begin n_fail++; $display("FAIL directed_fd_order: got cycle %0d want >= %0d", fd_cyc, last); end
    end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL directed_idle: got %0d want 0", dbg_state); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int held;
    bus.sink_busy = 1'b1;
    begin_frame();
    stream(PIX, 40, 1'b0);
    held = sent;
    n_cmp++; if (held != DEPTH - MARGIN + 1) begin n_fail++; $display("FAIL bp_accepted_while_busy: got %0d want %0d", held, DEPTH - MARGIN + 1); end
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_beats_while_busy: got %0d want 0", obs_q.size()); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready); end
    bus.sink_busy = 1'b0;
    stream(PIX, 300, 1'b0);
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_frame_done: got none within 300 cycles want pulse"); end
    n_cmp++; if (obs_q.size() != PIX || exp_q.size() != PIX) begin n_fail++; $display("FAIL bp_count: got %0d beats / %0d sent want %0d", obs_q.size(), exp_q.size(), PIX); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL bp_fd_pulses: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL bp_idle: got %0d want 0", dbg_state); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    bus.sink_busy = 1'b0;
    begin_frame();
    stream(5, 50, 1'b1);
    start = 1'b1;
    stream(6, 50, 1'b0);
    start = 1'b0;
    stream(PIX, 300, 1'b1);
    n_cmp++; if (dbg_state !== 2'd2) begin n_fail++; $display("FAIL start_in_drain_state: got %0d want 2", dbg_state); end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(300, ok);
    tick(10);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL start_frame_done: got none within 300 cycles want pulse"); end
    n_cmp++; if (obs_q.size() != PIX || exp_q.size() != PIX) begin n_fail++; $display("FAIL start_count: got %0d beats / %0d sent want %0d", obs_q.size(), exp_q.size(), PIX); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL start_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL start_fd_pulses: got %0d want 1", fd_cnt - fd0); end
    n_cmp++; if (dbg_state !== 2'd0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL start_not_restarted: got state %0d in_ready %b want 0 0", dbg_state, bus.in_ready); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bus.sink_busy = 1'b0;
    begin_frame();
    stream(7, 50, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_data_valid: got %b want 0", bus.data_valid); end
    n_cmp++; if ({bus.Diff1, bus.Diff2, bus.Diff3} !== 48'h0) begin n_fail++; $display("FAIL midrst_diffs: got %h want 0", {bus.Diff1, bus.Diff2, bus.Diff3}); end
    n_cmp++; if (dbg_state !== 2'd0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got %0d fd %b want 0 0", dbg_state, frame_done); end
    tick(2);
    rst_n = 1'b1;
    obs_q.delete();
    obs_cyc_q.delete();
    bus.in_valid = 1'b1;
    tick(10);
    bus.in_valid = 1'b0;
    n_cmp++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_beats: got %0d want 0", obs_q.size()); end
    rand_busy = 1'b1;
    begin_frame();
    stream(PIX, 600, 1'b1);
    rand_busy = 1'b0;
    wait_done(300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL midrst_frame_done: got none within 300 cycles want pulse"); end
    n_cmp++; if (obs_q.size() != PIX || exp_q.size() != PIX) begin n_fail++; $display("FAIL midrst_count: got %0d beats / %0d sent want %0d", obs_q.size(), exp_q.size(), PIX); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL midrst_fd_pulses: got %0d want 1", fd_cnt - fd0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.g0 = 8'h0;
    bus.g1 = 8'h0;
    bus.g2 = 8'h0;
    bus.g3 = 8'h0;
    bus.in_valid = 1'b0;
    bus.sink_busy = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
